// File: rtl/neopix_strip_scheduler.sv
// neopix_strip_scheduler
// Shares one WS2812 bit encoder among NUM_STRIPS strip channels. Frame-ready
// pulses are latched as pending requests, granted round-robin, and every
// frame is followed by a guaranteed encoder-idle latch gap. An optional
// refresh timer periodically re-queues every strip.
//
// Ports:
//   clk_i        system clock, all logic on the rising edge
//   reset_n_i    synchronous active-low reset
//   frame_rdy_i  per-strip one-cycle frame-loaded pulse
//   enc_bsy_i    shared encoder busy (high while shifting pixels)
//   start_o      one-cycle encoder start pulse
//   sel_o        binary index of the granted strip (holds last value when idle)
//   grant_o      one-hot grant, held from START through the end of LATCH
//   pending_o    current pending-request flags
//   err_o        sticky start-timeout flag, cleared only by reset
module neopix_strip_scheduler #(
   parameter int unsigned NUM_STRIPS    = 2,
   parameter int unsigned SYSTEM_CLOCK  = 50000000,
   parameter int unsigned LATCH_US      = 80,
   parameter int unsigned REFRESH_HZ    = 0,
   parameter int unsigned START_TIMEOUT = 4,
   localparam int unsigned SEL_W = (NUM_STRIPS > 1) ? $clog2(NUM_STRIPS) : 1
) (
   input  logic                  clk_i,
   input  logic                  reset_n_i,
   input  logic [NUM_STRIPS-1:0] frame_rdy_i,
   input  logic                  enc_bsy_i,
   output logic                  start_o,
   output logic [SEL_W-1:0]      sel_o,
   output logic [NUM_STRIPS-1:0] grant_o,
   output logic [NUM_STRIPS-1:0] pending_o,
   output logic                  err_o
);

   localparam int unsigned LATCH_CYCLES = SYSTEM_CLOCK / 1000000 * LATCH_US;
   localparam int unsigned LATCH_LAST   = (LATCH_CYCLES > 0) ? LATCH_CYCLES - 1 : 0;
   localparam int unsigned TO_LAST      = (START_TIMEOUT > 0) ? START_TIMEOUT - 1 : 0;
   localparam int unsigned CNT_MAX      = (LATCH_LAST > TO_LAST) ? LATCH_LAST : TO_LAST;
   localparam int unsigned CNT_W        = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_BUSY,
      ST_LATCH
   } state_e;

   state_e                state_q,   state_d;
   logic                  start_q,   start_d;
   logic [SEL_W-1:0]      sel_q,     sel_d;
   logic [NUM_STRIPS-1:0] grant_q,   grant_d;
   logic [NUM_STRIPS-1:0] pending_q, pending_d;
   logic [SEL_W-1:0]      rr_q,      rr_d;
   logic [CNT_W-1:0]      cnt_q,     cnt_d;
   logic                  seen_q,    seen_d;
   logic                  err_q,     err_d;

   logic                  refresh_c;
   logic [NUM_STRIPS-1:0] clr_c;
   logic [SEL_W-1:0]      win_idx_c;
   logic                  win_found_c;

   // Optional free-running refresh timer; wrap re-queues every strip.
   if (REFRESH_HZ != 0) begin : g_refresh
      localparam int unsigned REFRESH_CYCLES = SYSTEM_CLOCK / REFRESH_HZ;
      localparam int unsigned REF_LAST       = (REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0;
      localparam int unsigned REF_W          = (REF_LAST > 0) ? $clog2(REF_LAST + 1) : 1;

      logic [REF_W-1:0] ref_q, ref_d;

      always_comb begin
         ref_d = ref_q + REF_W'(1);
         if (ref_q == REF_W'(REF_LAST)) begin
            ref_d = '0;
         end
      end

      always_ff @(posedge clk_i) begin
         if (!reset_n_i) begin
            ref_q <= '0;
         end else begin
            ref_q <= ref_d;
         end
      end

      assign refresh_c = (ref_q == REF_W'(REF_LAST));
   end else begin : g_no_refresh
      assign refresh_c = 1'b0;
   end

   // Round-robin winner: first pending index after the last grant.
   always_comb begin
      win_idx_c   = '0;
      win_found_c = 1'b0;
      for (int unsigned i = 1; i <= NUM_STRIPS; i++) begin
         if (!win_found_c && pending_q[SEL_W'((32'(rr_q) + i) % NUM_STRIPS)]) begin
            win_found_c = 1'b1;
            win_idx_c   = SEL_W'((32'(rr_q) + i) % NUM_STRIPS);
         end
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      start_d = 1'b0;
      sel_d   = sel_q;
      grant_d = grant_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      seen_d  = seen_q;
      err_d   = err_q;
      clr_c   = '0;

      case (state_q)
         ST_IDLE: begin
            if (win_found_c) begin
               state_d = ST_START;
               start_d = 1'b1;
               sel_d   = win_idx_c;
               grant_d = NUM_STRIPS'(1) << win_idx_c;
               rr_d    = win_idx_c;
            end
         end
         ST_START: begin
            // Served strip's request retires here; a coincident new pulse still sets it.
            clr_c   = grant_q;
            state_d = ST_BUSY;
            cnt_d   = '0;
            seen_d  = 1'b0;
         end
         ST_BUSY: begin
            if (enc_bsy_i) begin
               seen_d = 1'b1;
            end
            if (seen_q && !enc_bsy_i) begin
               state_d = ST_LATCH;
               cnt_d   = '0;
            end else if (!seen_q && !enc_bsy_i && (cnt_q == CNT_W'(TO_LAST))) begin
               // Encoder never acknowledged; flag it and still honour the latch gap.
               err_d   = 1'b1;
               state_d = ST_LATCH;
               cnt_d   = '0;
            end else if (!seen_q) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_LATCH: begin
            if (cnt_q == CNT_W'(LATCH_LAST)) begin
               state_d = ST_IDLE;
               grant_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase

      pending_d = (pending_q & ~clr_c) | frame_rdy_i | {NUM_STRIPS{refresh_c}};
   end

   // State and output registers.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q   <= ST_IDLE;
         start_q   <= 1'b0;
         sel_q     <= '0;
         grant_q   <= '0;
         pending_q <= '0;
         rr_q      <= SEL_W'(NUM_STRIPS - 1);
         cnt_q     <= '0;
         seen_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         start_q   <= start_d;
         sel_q     <= sel_d;
         grant_q   <= grant_d;
         pending_q <= pending_d;
         rr_q      <= rr_d;
         cnt_q     <= cnt_d;
         seen_q    <= seen_d;
         err_q     <= err_d;
      end
   end

   assign start_o   = start_q;
   assign sel_o     = sel_q;
   assign grant_o   = grant_q;
   assign pending_o = pending_q;
   assign err_o     = err_q;

endmodule

// File: tb/tb_neopix_strip_scheduler.sv
// tb_neopix_strip_scheduler
// Scoreboard bench: a timestamp-based reference model predicts, per cycle,
// the grant/pending/sel/err outputs and the cycle and strip of every encoder
// start. A monitor compares them as the DUT presents them. A second instance
// with the refresh timer enabled checks the periodic re-queue.
module tb_neopix_strip_scheduler;

   localparam int N     = 2;
   localparam int LATCH = 10;
   localparam int TO    = 4;
   localparam int INF   = 32'h7fffffff;

   logic       clk = 1'b0;
   int         cyc = 0;
   logic       reset_n;
   logic       reset_b_n;
   logic [1:0] frame_rdy;
   logic       enc_bsy;

   logic       start_a, sel_a, err_a;
   logic [1:0] grant_a, pending_a;
   logic       start_b, sel_b, err_b;
   logic [1:0] grant_b, pending_b;

   int checks = 0;
   int passes = 0;

   typedef struct {
      int         cyc;
      logic [1:0] grant;
      logic [1:0] pend;
      int         sel;
      logic       err;
   } cyc_rec_t;

   typedef struct {
      int cyc;
      int sel;
   } start_rec_t;

   typedef struct {
      int r;
      int d;
   } enc_rec_t;

   cyc_rec_t   cyc_q[$];
   start_rec_t st_q[$];
   enc_rec_t   enc_q[$];

   // Reference model state (timestamps in cycles)
   logic [1:0] m_pend;
   int         m_rr, m_sel, m_fs, m_fw, m_fend, m_err_from;
   int         enc_mode;

   neopix_strip_scheduler #(
      .NUM_STRIPS(2), .SYSTEM_CLOCK(1000000), .LATCH_US(10),
      .REFRESH_HZ(0), .START_TIMEOUT(4)
   ) dut (
      .clk_i(clk), .reset_n_i(reset_n), .frame_rdy_i(frame_rdy),
      .enc_bsy_i(enc_bsy), .start_o(start_a), .sel_o(sel_a),
      .grant_o(grant_a), .pending_o(pending_a), .err_o(err_a)
   );

   neopix_strip_scheduler #(
      .NUM_STRIPS(2), .SYSTEM_CLOCK(1000000), .LATCH_US(10),
      .REFRESH_HZ(1000), .START_TIMEOUT(4)
   ) dut_r (
      .clk_i(clk), .reset_n_i(reset_b_n), .frame_rdy_i(2'b00),
      .enc_bsy_i(1'b0), .start_o(start_b), .sel_o(sel_b),
      .grant_o(grant_b), .pending_o(pending_b), .err_o(err_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end else begin
         passes++;
      end
   endtask

   // One cycle: record model outputs, arbitrate if idle, drive inputs, advance.
   task automatic step(input logic [1:0] req, input logic rst);
      int         c, w, cand, s, r, d, fend;
      bit         found;
      cyc_rec_t   rec;
      start_rec_t sr;
      enc_rec_t   er;
      logic [1:0] clr;
      c = cyc;
      if (c == m_fs) m_sel = m_fw;
      rec.cyc   = c;
      rec.grant = (c >= m_fs && c < m_fend) ? 2'(1 << m_fw) : 2'b00;
      rec.pend  = m_pend;
      rec.sel   = m_sel;
      rec.err   = (c >= m_err_from);
      cyc_q.push_back(rec);

      if (!rst && c >= m_fend && m_pend != 2'b00) begin
         found = 0;
         w     = 0;
         for (int i = 1; i <= N; i++) begin
            cand = (m_rr + i) % N;
            if (!found && m_pend[cand]) begin
               found = 1;
               w     = cand;
            end
         end
         s = c + 1;
         case (enc_mode)
            0:       begin r = int'($urandom_range(1, 3)); d = int'($urandom_range(1, 12)); end
            1:       begin r = 1; d = 20; end
            default: begin r = 0; d = 0; end
         endcase
         if (r == 0) begin
            fend = s + TO + 1 + LATCH;
            if (m_err_from > s + TO + 1) m_err_from = s + TO + 1;
         end else begin
            fend = s + r + d + LATCH + 1;
         end
         sr.cyc = s;
         sr.sel = w;
         st_q.push_back(sr);
         er.r = r;
         er.d = d;
         enc_q.push_back(er);
         m_fs   = s;
         m_fw   = w;
         m_fend = fend;
         m_rr   = w;
      end

      reset_n   = !rst;
      frame_rdy = rst ? 2'b00 : req;
      if (rst) begin
         m_pend     = 2'b00;
         m_fend     = c + 1;
         m_fs       = -1;
         m_rr       = N - 1;
         m_sel      = 0;
         m_err_from = INF;
      end else begin
         clr    = (c == m_fs) ? 2'(1 << m_fw) : 2'b00;
         m_pend = (m_pend & ~clr) | req;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(2'b00, 1'b0);
   endtask

   // Encoder model: responds to start_o with the behaviour the model chose.
   enc_rec_t enc_r;
   initial begin
      enc_bsy = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (start_a === 1'b1 && enc_q.size() != 0) begin
            enc_r = enc_q.pop_front();
            if (enc_r.r != 0) begin
               repeat (enc_r.r) @(posedge clk);
               #2;
               enc_bsy = 1'b1;
               repeat (enc_r.d) @(posedge clk);
               #2;
               enc_bsy = 1'b0;
            end
         end
      end
   end

   // Monitor: per-cycle output compare plus start-pulse scoreboard.
   cyc_rec_t   mon_r;
   start_rec_t mon_s;
   initial begin
      forever begin
         @(negedge clk);
         if (cyc_q.size() != 0) begin
            mon_r = cyc_q.pop_front();
            chk("grant",   grant_a,   mon_r.grant);
            chk("pending", pending_a, mon_r.pend);
            chk("sel",     sel_a,     mon_r.sel);
            chk("err",     err_a,     mon_r.err);
         end
         if (start_a === 1'b1) begin
            if (st_q.size() == 0) begin
               checks++;
               $display("FAIL start_unexpected cycle %0d: got start_o=1 expected no start", cyc);
            end else begin
               mon_s = st_q.pop_front();
               chk("start_cycle", cyc,   mon_s.cyc);
               chk("start_sel",   sel_a, mon_s.sel);
            end
         end
      end
   end

   // Refresh instance: timer wraps every 1000 cycles from the first running cycle 4.
   initial begin
      wait (cyc == 1003); #3;
      chk("refresh_pre1",  pending_b, 2'b00);
      wait (cyc == 1004); #3;
      chk("refresh_wrap1", pending_b, 2'b11);
      wait (cyc == 1005); #3;
      chk("refresh_start", start_b, 1'b1);
      chk("refresh_grant", grant_b, 2'b01);
      chk("refresh_sel",   sel_b,   1'b0);
      wait (cyc == 1009); #3;
      chk("timeout_err_pre", err_b, 1'b0);
      wait (cyc == 1010); #3;
      chk("timeout_err",     err_b, 1'b1);
      wait (cyc == 2003); #3;
      chk("refresh_pre2",  pending_b, 2'b00);
      wait (cyc == 2004); #3;
      chk("refresh_wrap2", pending_b, 2'b11);
   end

   initial begin
      reset_n    = 1'b0;
      reset_b_n  = 1'b0;
      frame_rdy  = 2'b00;
      m_pend     = 2'b00;
      m_rr       = N - 1;
      m_sel      = 0;
      m_fs       = -1;
      m_fw       = 0;
      m_fend     = 0;
      m_err_from = INF;
      enc_mode   = 1;
      repeat (4) @(posedge clk);
      #1;
      reset_n   = 1'b1;
      reset_b_n = 1'b1;
      chk("reset_start", start_a, 1'b0);

      // single request, then simultaneous requests
      step(2'b01, 1'b0);
      idle(40);
      step(2'b11, 1'b0);
      idle(80);
      // fairness: both strips keep re-requesting
      for (int i = 0; i < 220; i++) step((i % 5 == 0) ? 2'b11 : 2'b00, 1'b0);
      idle(80);
      // re-request of strip 0 while its own frame is busy
      step(2'b01, 1'b0);
      idle(6);
      step(2'b01, 1'b0);
      idle(80);
      // randomized traffic
      enc_mode = 0;
      for (int i = 0; i < 1200; i++) begin
         if ($urandom_range(0, 7) == 0) step(2'($urandom_range(1, 3)), 1'b0);
         else                           step(2'b00, 1'b0);
      end
      idle(80);
      // start timeout: encoder never goes busy
      enc_mode = 2;
      step(2'b10, 1'b0);
      idle(30);
      // reset in the middle of a busy frame, then normal service resumes
      enc_mode = 1;
      step(2'b01, 1'b0);
      idle(6);
      step(2'b00, 1'b1);
      idle(40);
      step(2'b10, 1'b0);
      idle(40);
      while (cyc < 2030) step(2'b00, 1'b0);
      @(posedge clk);
      #1;
      chk("start_queue_drained", st_q.size(), 0);
      chk("cycle_queue_drained", cyc_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
